// File: rtl/disp_rdsched.sv
// Per-frame AXI burst read scheduler: FIFO flush 5 ACLK after the VSYNC fall, then one AR every 2 cycles at most.
// ARVALID/ARADDR hold until ARREADY; new requests wait for FIFO room (level+pending+burst) and a free outstanding slot.
module disp_rdsched #(
  parameter int FRAME_BURSTS = 9600,
  parameter int BURST_LEN    = 16,
  parameter int FIFO_DEPTH   = 1024,
  parameter int MAX_OUTS     = 4
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic        DISPON,
  input  logic [28:0] DISPADDR,
  input  logic        DSP_VSYNC_X,
  input  logic [10:0] FIFO_LEVEL,
  output logic [31:0] ARADDR,
  output logic [7:0]  ARLEN,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic        RVALID,
  output logic        RREADY,
  input  logic        RLAST,
  output logic        FIFO_FLUSH,
  output logic        BUSY,
  output logic        FRAME_DONE,
  output logic        LATE_ERR
);

  localparam logic [31:0] STRIDE     = 32'(BURST_LEN * 8);
  localparam logic [13:0] LAST_BURST = 14'(FRAME_BURSTS - 1);
  localparam logic [13:0] ALL_BURSTS = 14'(FRAME_BURSTS);
  localparam logic [10:0] BLEN       = 11'(BURST_LEN);
  localparam logic [11:0] BLEN12     = 12'(BURST_LEN);
  localparam logic [11:0] DEPTH12    = 12'(FIFO_DEPTH);
  localparam logic [2:0]  OUTS_MAX   = 3'(MAX_OUTS);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_ISSUE, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic        vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d, vs_s3_q, vs_s3_d;
  logic        vs_fall_q, vs_fall_d;
  logic [31:0] base_q, base_d;
  logic [13:0] burst_cnt_q, burst_cnt_d;
  logic [2:0]  outs_q, outs_d;
  logic [10:0] pend_q, pend_d;
  logic        arvalid_q, arvalid_d;
  logic [31:0] araddr_q, araddr_d;
  logic        fifo_flush_q, fifo_flush_d;
  logic        frame_done_q, frame_done_d;
  logic        late_err_q, late_err_d;

  logic        ar_hs, r_last, credit, drained;
  logic [11:0] level_sum;

  assign ar_hs     = arvalid_q & ARREADY;
  assign r_last    = RVALID & RLAST;
  assign level_sum = {1'b0, FIFO_LEVEL} + {1'b0, pend_q} + BLEN12;
  assign credit    = (level_sum <= DEPTH12) && (outs_q < OUTS_MAX);
  assign drained   = (outs_q == 3'd0) && (pend_q == 11'd0);

  always_comb begin
    vs_s1_d   = DSP_VSYNC_X;
    vs_s2_d   = vs_s1_q;
    vs_s3_d   = vs_s2_q;
    vs_fall_d = vs_s3_q & ~vs_s2_q;

    // Protocol-error returns (nothing outstanding) saturate at zero.
    outs_d = outs_q;
    if (ar_hs && !r_last)
      outs_d = outs_q + 3'd1;
    else if (!ar_hs && r_last && outs_q != 3'd0)
      outs_d = outs_q - 3'd1;

    pend_d = pend_q;
    if (ar_hs && RVALID)
      pend_d = pend_q + BLEN - 11'd1;
    else if (ar_hs)
      pend_d = pend_q + BLEN;
    else if (RVALID && pend_q != 11'd0)
      pend_d = pend_q - 11'd1;
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    burst_cnt_d  = burst_cnt_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    fifo_flush_d = 1'b0;
    frame_done_d = 1'b0;
    late_err_d   = vs_fall_q && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (vs_fall_q && DISPON) begin
          base_d      = {DISPADDR, 3'b000};
          burst_cnt_d = 14'd0;
          state_d     = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (drained) begin
          fifo_flush_d = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (arvalid_q) begin
          // A raised request is never withdrawn; DISPON is only honoured after its handshake.
          if (ARREADY) begin
            arvalid_d   = 1'b0;
            burst_cnt_d = burst_cnt_q + 14'd1;
            if (burst_cnt_q == LAST_BURST || !DISPON)
              state_d = S_DRAIN;
          end
        end else if (!DISPON) begin
          state_d = S_DRAIN;
        end else if (credit) begin
          arvalid_d = 1'b1;
          araddr_d  = base_q + 32'(burst_cnt_q) * STRIDE;
        end
      end
      S_DRAIN: begin
        if (drained) begin
          frame_done_d = (burst_cnt_q == ALL_BURSTS);
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q      <= S_IDLE;
      vs_s1_q      <= 1'b1;
      vs_s2_q      <= 1'b1;
      vs_s3_q      <= 1'b1;
      vs_fall_q    <= 1'b0;
      base_q       <= 32'd0;
      burst_cnt_q  <= 14'd0;
      outs_q       <= 3'd0;
      pend_q       <= 11'd0;
      arvalid_q    <= 1'b0;
      araddr_q     <= 32'd0;
      fifo_flush_q <= 1'b0;
      frame_done_q <= 1'b0;
      late_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_s1_q      <= vs_s1_d;
      vs_s2_q      <= vs_s2_d;
      vs_s3_q      <= vs_s3_d;
      vs_fall_q    <= vs_fall_d;
      base_q       <= base_d;
      burst_cnt_q  <= burst_cnt_d;
      outs_q       <= outs_d;
      pend_q       <= pend_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      fifo_flush_q <= fifo_flush_d;
      frame_done_q <= frame_done_d;
      late_err_q   <= late_err_d;
    end
  end

  assign ARADDR     = araddr_q;
  assign ARLEN      = 8'(BURST_LEN - 1);
  assign ARVALID    = arvalid_q;
  assign RREADY     = 1'b1;
  assign FIFO_FLUSH = fifo_flush_q;
  assign BUSY       = (state_q != S_IDLE);
  assign FRAME_DONE = frame_done_q;
  assign LATE_ERR   = late_err_q;

endmodule

// File: tb/tb_disp_rdsched.sv
// Bench for disp_rdsched: directed frame scenarios plus randomized AR/R timing and FIFO level,
// checked against a transaction-level model of addresses, outstanding bursts and pending beats.
module tb_disp_rdsched;
  localparam int FB = 8;
  localparam int BIG = 1 << 30;

  logic        ACLK = 1'b0;
  logic        ARST, DISPON, DSP_VSYNC_X;
  logic [28:0] DISPADDR;
  logic [10:0] FIFO_LEVEL;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic        FIFO_FLUSH, BUSY, FRAME_DONE, LATE_ERR;

  always #5 ACLK = ~ACLK;

  disp_rdsched #(.FRAME_BURSTS(FB), .BURST_LEN(16), .FIFO_DEPTH(1024), .MAX_OUTS(4)) dut (
    .ACLK(ACLK), .ARST(ARST), .DISPON(DISPON), .DISPADDR(DISPADDR), .DSP_VSYNC_X(DSP_VSYNC_X),
    .FIFO_LEVEL(FIFO_LEVEL), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .FIFO_FLUSH(FIFO_FLUSH), .BUSY(BUSY),
    .FRAME_DONE(FRAME_DONE), .LATE_ERR(LATE_ERR));

  int checks = 0, failures = 0;

  // Environment controls: ar_mode 0 = ARREADY low, 1 = ready, 2 = random.
  int ar_mode = 1, ar_limit = BIG, r_budget = BIG, r_pct = 100;

  // Reference model state.
  logic [31:0] mdl_base = 32'd0;
  int          mdl_issued = 0, mdl_pend = 0, mdl_outs = 0, beat_idx = 0;
  int          hs_total = 0, flush_cnt = 0, done_cnt = 0, late_cnt = 0;
  logic        prev_vld = 1'b0, prev_rdy = 1'b0, prev_rst = 1'b1, credit_prev = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  int          f0, d0, l0, h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic snap();
    f0 = flush_cnt; d0 = done_cnt; l0 = late_cnt; h0 = hs_total;
  endtask

  task automatic vsync_fall();
    DSP_VSYNC_X = 1'b0;
    tick(6);
    DSP_VSYNC_X = 1'b1;
    tick(2);
  endtask

  task automatic start_frame();
    mdl_base   = {DISPADDR, 3'b000};
    mdl_issued = 0;
    vsync_fall();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (BUSY && n < 4000) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(BUSY), 32'd0);
    tick(2);
  endtask

  // AXI slave + monitor: drives ARREADY/R at the falling edge and tracks the model.
  initial begin
    ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
    forever begin
      @(negedge ACLK);
      if (FIFO_FLUSH) flush_cnt++;
      if (FRAME_DONE) done_cnt++;
      if (LATE_ERR)   late_cnt++;
      if (ARST) begin
        mdl_pend = 0; mdl_outs = 0; beat_idx = 0;
        RVALID = 1'b0; RLAST = 1'b0; ARREADY = 1'b0;
        prev_vld = 1'b0; prev_rst = 1'b1; credit_prev = 1'b0;
      end else begin
        if (!prev_rst && prev_vld && !prev_rdy) begin
          chk("ar_hold_vld", 32'(ARVALID), 32'd1);
          chk("ar_hold_addr", ARADDR, prev_addr);
        end
        if (!prev_rst && ARVALID && !prev_vld)
          chk("ar_credit", 32'(credit_prev), 32'd1);
        credit_prev = (int'(FIFO_LEVEL) + mdl_pend + 16 <= 1024) && (mdl_outs < 4);
        case (ar_mode)
          0:       ARREADY = 1'b0;
          1:       ARREADY = (hs_total < ar_limit);
          default: ARREADY = ($urandom_range(0, 1) == 1) && (hs_total < ar_limit);
        endcase
        RVALID = (r_budget > 0) && (mdl_pend > 0) && ($urandom_range(0, 99) < r_pct);
        RLAST  = RVALID && (beat_idx == 15);
        if (RVALID) begin
          r_budget--;
          mdl_pend--;
          beat_idx = RLAST ? 0 : beat_idx + 1;
          if (RLAST) mdl_outs--;
        end
        if (ARVALID && ARREADY) begin
          chk("ar_addr", ARADDR, mdl_base + 32'(mdl_issued) * 32'd128);
          chk("ar_len", 32'(ARLEN), 32'd15);
          mdl_issued++;
          hs_total++;
          mdl_pend += 16;
          mdl_outs++;
        end
        prev_vld = ARVALID; prev_rdy = ARREADY; prev_addr = ARADDR; prev_rst = 1'b0;
      end
    end
  end

  initial begin
    int k_flush, k_vld;
    logic [31:0] held_addr;
    ARST = 1'b1; DISPON = 1'b0; DISPADDR = 29'd0; DSP_VSYNC_X = 1'b1; FIFO_LEVEL = 11'd0;
    tick(3);
    chk("rst_arvalid", 32'(ARVALID), 32'd0);
    chk("rst_araddr", ARADDR, 32'd0);
    chk("rst_flush", 32'(FIFO_FLUSH), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(FRAME_DONE), 32'd0);
    chk("rst_late", 32'(LATE_ERR), 32'd0);
    chk("rst_arlen", 32'(ARLEN), 32'd15);
    chk("rst_rready", 32'(RREADY), 32'd1);
    ARST = 1'b0;
    tick(3);

    // Basic frame with VSYNC-to-request latency.
    DISPON = 1'b1; DISPADDR = 29'h0100_0000; ar_mode = 1; r_pct = 100;
    snap();
    mdl_base = 32'h0800_0000; mdl_issued = 0;
    DSP_VSYNC_X = 1'b0;
    k_flush = 0; k_vld = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (FIFO_FLUSH && k_flush == 0) k_flush = k;
      if (ARVALID && k_vld == 0) k_vld = k;
    end
    DSP_VSYNC_X = 1'b1;
    chk("lat_flush", 32'(k_flush), 32'd5);
    chk("lat_arvalid", 32'(k_vld), 32'd6);
    wait_idle("t1_idle");
    chk("t1_flush", 32'(flush_cnt - f0), 32'd1);
    chk("t1_done", 32'(done_cnt - d0), 32'd1);
    chk("t1_hs", 32'(hs_total - h0), 32'(FB));
    chk("t1_late", 32'(late_cnt - l0), 32'd0);

    // Randomized frame near the top of the address space (wraps), random ready/level/R.
    DISPADDR = 29'h1FFF_FF00 | 29'($urandom_range(0, 255));
    ar_mode = 2; r_pct = 40;
    snap();
    start_frame();
    for (int n = 0; n < 6000; n++) begin
      FIFO_LEVEL = 11'($urandom_range(0, 1023));
      tick(1);
      if (!BUSY) break;
    end
    FIFO_LEVEL = 11'd0;
    tick(2);
    chk("t2_busy", 32'(BUSY), 32'd0);
    chk("t2_done", 32'(done_cnt - d0), 32'd1);
    chk("t2_hs", 32'(hs_total - h0), 32'(FB));
    chk("t2_flush", 32'(flush_cnt - f0), 32'd1);

    // Credit boundary: 1009+0+16 > 1024 blocks, 1008 allows exactly one.
    DISPADDR = 29'h0000_1000; ar_mode = 1; r_pct = 100; r_budget = 0; FIFO_LEVEL = 11'd1009;
    snap();
    start_frame();
    tick(20);
    chk("t3_none", 32'(hs_total - h0), 32'd0);
    chk("t3_busy", 32'(BUSY), 32'd1);
    FIFO_LEVEL = 11'd1008;
    tick(20);
    chk("t3_one", 32'(hs_total - h0), 32'd1);
    chk("t3_novld", 32'(ARVALID), 32'd0);
    FIFO_LEVEL = 11'd993;
    tick(20);
    chk("t3_still_one", 32'(hs_total - h0), 32'd1);
    FIFO_LEVEL = 11'd992;
    tick(20);
    chk("t3_two", 32'(hs_total - h0), 32'd2);
    FIFO_LEVEL = 11'd0; r_budget = BIG;
    wait_idle("t3_idle");
    chk("t3_done", 32'(done_cnt - d0), 32'd1);

    // Outstanding limit with no R data, then one burst returned.
    r_budget = 0;
    snap();
    start_frame();
    tick(40);
    chk("t4_four", 32'(hs_total - h0), 32'd4);
    chk("t4_novld", 32'(ARVALID), 32'd0);
    r_budget = 16;
    tick(60);
    chk("t4_five", 32'(hs_total - h0), 32'd5);
    r_budget = BIG;
    wait_idle("t4_idle");
    chk("t4_done", 32'(done_cnt - d0), 32'd1);

    // DISPON dropped with a request stalled on ARREADY.
    ar_mode = 0; DISPADDR = 29'h0040_0000;
    snap();
    start_frame();
    chk("t5_vld", 32'(ARVALID), 32'd1);
    chk("t5_addr", ARADDR, 32'h0200_0000);
    held_addr = ARADDR;
    DISPON = 1'b0;
    tick(5);
    chk("t5_hold_vld", 32'(ARVALID), 32'd1);
    chk("t5_hold_addr", ARADDR, held_addr);
    ar_mode = 1;
    wait_idle("t5_idle");
    chk("t5_hs", 32'(hs_total - h0), 32'd1);
    chk("t5_nodone", 32'(done_cnt - d0), 32'd0);
    DISPON = 1'b1;

    // Second VSYNC during ISSUE.
    r_pct = 30; DISPADDR = 29'h0123_4560;
    snap();
    start_frame();
    chk("t6_busy", 32'(BUSY), 32'd1);
    vsync_fall();
    wait_idle("t6_idle");
    chk("t6_late", 32'(late_cnt - l0), 32'd1);
    chk("t6_done", 32'(done_cnt - d0), 32'd1);
    chk("t6_hs", 32'(hs_total - h0), 32'(FB));
    tick(15);
    chk("t6_stay_idle", 32'(BUSY), 32'd0);
    chk("t6_flush", 32'(flush_cnt - f0), 32'd1);

    // Reset mid-frame with two bursts outstanding, then a clean frame at a new base.
    r_pct = 100; r_budget = 0; ar_limit = hs_total + 2; DISPADDR = 29'h0200_0000;
    snap();
    start_frame();
    tick(30);
    chk("t7_two", 32'(hs_total - h0), 32'd2);
    chk("t7_outs_pre", 32'(dut.outs_q), 32'd2);
    ARST = 1'b1;
    tick(1);
    chk("t7_vld", 32'(ARVALID), 32'd0);
    chk("t7_busy", 32'(BUSY), 32'd0);
    chk("t7_outs", 32'(dut.outs_q), 32'd0);
    chk("t7_pend", 32'(dut.pend_q), 32'd0);
    chk("t7_bcnt", 32'(dut.burst_cnt_q), 32'd0);
    ARST = 1'b0; ar_limit = BIG; r_budget = BIG; DISPADDR = 29'h0300_0040;
    tick(2);
    snap();
    start_frame();
    wait_idle("t7_idle");
    chk("t7_done", 32'(done_cnt - d0), 32'd1);
    chk("t7_hs", 32'(hs_total - h0), 32'(FB));
    chk("t7_flush", 32'(flush_cnt - f0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
